// File: rtl/sysid_read_arbiter.sv
// ---------------------------------------------------------------------------
// sysid_read_arbiter
//   Two-master read arbiter in front of a single-word-address system-ID slave
//   (word 0 = ID, word 1 = timestamp). The Nios II data master (m0) and a
//   debug/boot master (m1) share the slave. Reads are serialized with
//   round-robin fairness, and read data is registered towards the winner.
//
//   Optional feature macro: SYSID_ARB_STATS_EN adds saturating per-master
//   counters of completed (acked) grants.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   mX_read/mX_address  master X read request (held until waitrequest low)
//   mX_waitrequest      high while master X request is pending
//   mX_readdata         registered read data, valid in the ack cycle
//   s_address/s_readdata  registered address to / data from the slave
//   busy                high whenever the FSM is not idle
//   mX_grant_count      completed grants (SYSID_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module sysid_read_arbiter #(
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 0,
  parameter int CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_read,
  input  logic              m0_address,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic              m1_read,
  input  logic              m1_address,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              s_address,
  input  logic [DATA_W-1:0] s_readdata,
  output logic              busy
`ifdef SYSID_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  m0_grant_count,
  output logic [CNT_W-1:0]  m1_grant_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t            state_reg, state_next;
  logic              grant_reg;
  logic              rr_last_reg;
  logic              ack0_reg, ack1_reg;
  logic [2:0]        lat_cnt_reg;
  logic              s_address_reg;
  logic [DATA_W-1:0] m0_readdata_reg, m1_readdata_reg;

  logic req0, req1, any_req, grant_now, granted_read;

  // A master is held off from re-arbitration in its own ack cycle: its read
  // is still high there, but that request is the one being completed.
  assign req0    = m0_read & ~ack0_reg;
  assign req1    = m1_read & ~ack1_reg;
  assign any_req = req0 | req1;

  // Single requester wins outright; on a tie the master that did not win last.
  assign grant_now    = (req0 & req1) ? ~rr_last_reg : req1;
  assign granted_read = grant_reg ? m1_read : m0_read;

  assign m0_waitrequest = m0_read & ~ack0_reg;
  assign m1_waitrequest = m1_read & ~ack1_reg;
  assign m0_readdata    = m0_readdata_reg;
  assign m1_readdata    = m1_readdata_reg;
  assign s_address      = s_address_reg;
  assign busy           = (state_reg != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = (READ_LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (lat_cnt_reg <= 3'd1) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_reg       <= 1'b0;
      rr_last_reg     <= 1'b1;
      ack0_reg        <= 1'b0;
      ack1_reg        <= 1'b0;
      lat_cnt_reg     <= 3'd0;
      s_address_reg   <= 1'b0;
      m0_readdata_reg <= '0;
      m1_readdata_reg <= '0;
    end else begin
      ack0_reg <= 1'b0;
      ack1_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_reg     <= grant_now;
            s_address_reg <= grant_now ? m1_address : m0_address;
            lat_cnt_reg   <= LAT;
          end
        end
        WAIT: begin
          lat_cnt_reg <= lat_cnt_reg - 3'd1;
        end
        RESP: begin
          // Fairness advances even if the winner abandoned its request.
          rr_last_reg <= grant_reg;
          if (granted_read) begin
            if (grant_reg) begin
              m1_readdata_reg <= s_readdata;
              ack1_reg        <= 1'b1;
            end else begin
              m0_readdata_reg <= s_readdata;
              ack0_reg        <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SYSID_ARB_STATS_EN
  logic [CNT_W-1:0] m0_cnt_reg, m1_cnt_reg;

  assign m0_grant_count = m0_cnt_reg;
  assign m1_grant_count = m1_cnt_reg;

  // Counts only reads that were actually acked; saturates at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m0_cnt_reg <= '0;
      m1_cnt_reg <= '0;
    end else if (state_reg == RESP && granted_read) begin
      if (grant_reg) begin
        if (m1_cnt_reg != '1) m1_cnt_reg <= m1_cnt_reg + CNT_W'(1);
      end else begin
        if (m0_cnt_reg != '1) m0_cnt_reg <= m0_cnt_reg + CNT_W'(1);
      end
    end
  end
`else
`endif

endmodule
